// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory bus between the IFU (read-only) and the LSU.
// One transaction in flight; responses are registered per requester; a watchdog turns a lost response into an error.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LSU_PRIORITY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_resp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [1:0]            lsu_mask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_mask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast =
      (TIMEOUT_CYCLES > 0) ? TimerW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WatchdogEn = (TIMEOUT_CYCLES != 0);
  localparam bit LsuFirst   = (LSU_PRIORITY != 0);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic {OwnIfu, OwnLsu} owner_e;

  state_e                state_q, state_d;
  // The owner of the current transaction is also the last grant used for tie-breaking.
  owner_e                owner_q, owner_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            mask_q, mask_d;
  logic                  ifu_resp_valid_q, ifu_resp_valid_d;
  logic                  ifu_resp_err_q, ifu_resp_err_d;
  logic [DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
  logic                  lsu_resp_valid_q, lsu_resp_valid_d;
  logic                  lsu_resp_err_q, lsu_resp_err_d;
  logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;

  logic ifu_wins, lsu_wins, idle;

  always_comb begin
    idle     = (state_q == StIdle);
    lsu_wins = lsu_req_valid & (~ifu_req_valid | LsuFirst | (owner_q == OwnIfu));
    ifu_wins = ifu_req_valid & ~lsu_wins;
  end

  assign ifu_req_ready  = idle & ifu_wins;
  assign lsu_req_ready  = idle & lsu_wins;
  assign mem_req_valid  = (state_q == StIssue);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_mask       = mask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_err   = ifu_resp_err_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_err   = lsu_resp_err_q;
  assign lsu_rdata      = lsu_rdata_q;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    timer_d          = timer_q;
    addr_d           = addr_q;
    wen_d            = wen_q;
    wdata_d          = wdata_q;
    mask_d           = mask_q;
    ifu_resp_valid_d = 1'b0;
    ifu_resp_err_d   = 1'b0;
    ifu_rdata_d      = ifu_rdata_q;
    lsu_resp_valid_d = 1'b0;
    lsu_resp_err_d   = 1'b0;
    lsu_rdata_d      = lsu_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (lsu_wins) begin
          state_d = StIssue;
          owner_d = OwnLsu;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          mask_d  = lsu_mask;
        end else if (ifu_wins) begin
          state_d = StIssue;
          owner_d = OwnIfu;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          mask_d  = 2'd2;
        end
      end
      StIssue: begin
        if (mem_req_ready) begin
          state_d = StWait;
          timer_d = '0;
        end
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (mem_resp_valid) begin
          state_d = StIdle;
          if (owner_q == OwnLsu) begin
            lsu_resp_valid_d = 1'b1;
            lsu_rdata_d      = mem_rdata;
          end else begin
            ifu_resp_valid_d = 1'b1;
            ifu_rdata_d      = mem_rdata;
          end
        end else if (WatchdogEn && (timer_q == TimerLast)) begin
          state_d = StIdle;
          if (owner_q == OwnLsu) begin
            lsu_resp_valid_d = 1'b1;
            lsu_resp_err_d   = 1'b1;
            lsu_rdata_d      = '0;
          end else begin
            ifu_resp_valid_d = 1'b1;
            ifu_resp_err_d   = 1'b1;
            ifu_rdata_d      = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= StIdle;
      owner_q          <= OwnIfu;
      timer_q          <= '0;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      mask_q           <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_err_q   <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_err_q   <= 1'b0;
      lsu_rdata_q      <= '0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      timer_q          <= timer_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      mask_q           <= mask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_err_q   <= ifu_resp_err_d;
      ifu_rdata_q      <= ifu_rdata_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_err_q   <= lsu_resp_err_d;
      lsu_rdata_q      <= lsu_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 is round-robin with a 4-cycle watchdog,
// instance 1 is LSU-priority with the watchdog disabled.
`timescale 1ns / 1ps
module tb_dmem_arbiter;

  localparam int NTxn   = 3000;
  localparam int MaxCyc = 60000;

  logic        clock;
  logic        reset;
  logic        ifu_req_valid [2];
  logic        ifu_req_ready [2];
  logic [31:0] ifu_addr      [2];
  logic        ifu_resp_valid[2];
  logic [31:0] ifu_rdata     [2];
  logic        ifu_resp_err  [2];
  logic        lsu_req_valid [2];
  logic        lsu_req_ready [2];
  logic [31:0] lsu_addr      [2];
  logic        lsu_wen       [2];
  logic [31:0] lsu_wdata     [2];
  logic [1:0]  lsu_mask      [2];
  logic        lsu_resp_valid[2];
  logic [31:0] lsu_rdata     [2];
  logic        lsu_resp_err  [2];
  logic        mem_req_valid [2];
  logic        mem_req_ready [2];
  logic [31:0] mem_addr      [2];
  logic        mem_wen       [2];
  logic [31:0] mem_wdata     [2];
  logic [1:0]  mem_mask      [2];
  logic        mem_resp_valid[2];
  logic [31:0] mem_rdata     [2];

  int n_tests;
  int n_fail;

  dmem_arbiter #(.LSU_PRIORITY(0), .TIMEOUT_CYCLES(4)) u_dut0 (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid[0]), .ifu_req_ready(ifu_req_ready[0]), .ifu_addr(ifu_addr[0]),
    .ifu_resp_valid(ifu_resp_valid[0]), .ifu_rdata(ifu_rdata[0]), .ifu_resp_err(ifu_resp_err[0]),
    .lsu_req_valid(lsu_req_valid[0]), .lsu_req_ready(lsu_req_ready[0]), .lsu_addr(lsu_addr[0]),
    .lsu_wen(lsu_wen[0]), .lsu_wdata(lsu_wdata[0]), .lsu_mask(lsu_mask[0]),
    .lsu_resp_valid(lsu_resp_valid[0]), .lsu_rdata(lsu_rdata[0]), .lsu_resp_err(lsu_resp_err[0]),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]), .mem_addr(mem_addr[0]),
    .mem_wen(mem_wen[0]), .mem_wdata(mem_wdata[0]), .mem_mask(mem_mask[0]),
    .mem_resp_valid(mem_resp_valid[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.LSU_PRIORITY(1), .TIMEOUT_CYCLES(0)) u_dut1 (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid[1]), .ifu_req_ready(ifu_req_ready[1]), .ifu_addr(ifu_addr[1]),
    .ifu_resp_valid(ifu_resp_valid[1]), .ifu_rdata(ifu_rdata[1]), .ifu_resp_err(ifu_resp_err[1]),
    .lsu_req_valid(lsu_req_valid[1]), .lsu_req_ready(lsu_req_ready[1]), .lsu_addr(lsu_addr[1]),
    .lsu_wen(lsu_wen[1]), .lsu_wdata(lsu_wdata[1]), .lsu_mask(lsu_mask[1]),
    .lsu_resp_valid(lsu_resp_valid[1]), .lsu_rdata(lsu_rdata[1]), .lsu_resp_err(lsu_resp_err[1]),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]), .mem_addr(mem_addr[1]),
    .mem_wen(mem_wen[1]), .mem_wdata(mem_wdata[1]), .mem_mask(mem_mask[1]),
    .mem_resp_valid(mem_resp_valid[1]), .mem_rdata(mem_rdata[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL global time limit: got hang, expected completion");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_phase();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs(input int d);
    ifu_req_valid[d]  = 1'b0;
    ifu_addr[d]       = '0;
    lsu_req_valid[d]  = 1'b0;
    lsu_addr[d]       = '0;
    lsu_wen[d]        = 1'b0;
    lsu_wdata[d]      = '0;
    lsu_mask[d]       = '0;
    mem_req_ready[d]  = 1'b0;
    mem_resp_valid[d] = 1'b0;
    mem_rdata[d]      = '0;
  endtask

  task automatic do_reset();
    drive_phase();
    reset = 1'b0;
    clear_inputs(0);
    clear_inputs(1);
    repeat (2) drive_phase();
    reset = 1'b1;
  endtask

  // Full single-beat load; returns which requester was granted (0 IFU, 1 LSU, -1 none).
  task automatic run_txn(input int d, input bit iv, input bit lv, input logic [31:0] data,
                         output int owner);
    owner = -1;
    drive_phase();
    ifu_req_valid[d] = iv;
    ifu_addr[d]      = 32'h0000_4000 ^ data;
    lsu_req_valid[d] = lv;
    lsu_addr[d]      = 32'h0000_8000 ^ data;
    lsu_wen[d]       = 1'b0;
    lsu_mask[d]      = 2'd2;
    mem_req_ready[d] = 1'b1;
    for (int k = 0; k < 4 && owner < 0; k++) begin
      @(negedge clock);
      if (ifu_req_ready[d] && lsu_req_ready[d]) owner = 2;
      else if (ifu_req_ready[d]) owner = 0;
      else if (lsu_req_ready[d]) owner = 1;
      if (owner < 0) drive_phase();
    end
    drive_phase();
    ifu_req_valid[d] = 1'b0;
    lsu_req_valid[d] = 1'b0;
    if (owner == 0 || owner == 1) begin
      @(negedge clock);
      check("txn issue", {mem_req_valid[d], mem_wen[d], mem_mask[d]}, 4'b1010);
      drive_phase();
      mem_resp_valid[d] = 1'b1;
      mem_rdata[d]      = data;
      @(negedge clock);
      drive_phase();
      mem_resp_valid[d] = 1'b0;
      @(negedge clock);
      check("txn resp pulse", {ifu_resp_valid[d], lsu_resp_valid[d]},
            (owner == 1) ? 2'b01 : 2'b10);
      check("txn rdata", (owner == 1) ? lsu_rdata[d] : ifu_rdata[d], data);
      check("txn err", {ifu_resp_err[d], lsu_resp_err[d]}, 2'b00);
    end
  endtask

  typedef struct {
    int dut;
    bit iv;
    bit lv;
    int exp_owner;
  } grant_vec_t;

  grant_vec_t vecs[14];

  // Stress-model state
  bit          ifu_pend, lsu_pend, lsu_w, cur_w;
  logic [31:0] ifu_a, lsu_a, lsu_wd, cur_addr, cur_wd, resp_data, exp_data;
  logic [1:0]  lsu_m, cur_m;
  logic [31:0] last_rd[2];
  bit          outstanding, issue_pend, exp_valid, exp_err, ei, el;
  int          exp_owner, exp_cycle, resp_cycle, win_lo, win_hi;
  int          accepted, done, cur_owner, model_last, cyc, dly, owner;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    clear_inputs(0);
    clear_inputs(1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check("reset ready", {ifu_req_ready[d], lsu_req_ready[d]}, 0);
      check("reset mem_req_valid", mem_req_valid[d], 0);
      check("reset mem fields", {mem_addr[d], mem_wen[d], mem_mask[d]}, 0);
      check("reset mem_wdata", mem_wdata[d], 0);
      check("reset resp flags",
            {ifu_resp_valid[d], ifu_resp_err[d], lsu_resp_valid[d], lsu_resp_err[d]}, 0);
      check("reset rdata", {ifu_rdata[d], lsu_rdata[d]}, 0);
    end
    drive_phase();
    reset = 1'b1;

    // Grant table: round-robin on dut0 starts with last_grant=IFU; dut1 always prefers LSU.
    vecs[0]  = '{0, 1, 1, 1};
    vecs[1]  = '{0, 1, 1, 0};
    vecs[2]  = '{0, 1, 1, 1};
    vecs[3]  = '{0, 1, 1, 0};
    vecs[4]  = '{0, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, 1};
    vecs[6]  = '{0, 0, 1, 1};
    vecs[7]  = '{0, 1, 1, 0};
    vecs[8]  = '{1, 1, 1, 1};
    vecs[9]  = '{1, 1, 1, 1};
    vecs[10] = '{1, 1, 1, 1};
    vecs[11] = '{1, 1, 1, 1};
    vecs[12] = '{1, 1, 0, 0};
    vecs[13] = '{1, 1, 1, 1};
    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].dut, vecs[i].iv, vecs[i].lv, 32'hA500_0000 + i, owner);
      check($sformatf("grant row %0d", i), owner, vecs[i].exp_owner);
    end

    // IFU read on dut1, response two cycles after the bus accepts.
    drive_phase();
    ifu_req_valid[1] = 1'b1;
    ifu_addr[1]      = 32'h8000_0000;
    mem_req_ready[1] = 1'b1;
    @(negedge clock);
    check("ifu rd ready", ifu_req_ready[1], 1);
    drive_phase();
    ifu_req_valid[1] = 1'b0;
    @(negedge clock);
    check("ifu rd issue", {mem_req_valid[1], mem_wen[1], mem_mask[1]}, 4'b1010);
    check("ifu rd addr", mem_addr[1], 32'h8000_0000);
    check("ifu rd wdata", mem_wdata[1], 0);
    drive_phase();
    @(negedge clock);
    drive_phase();
    mem_resp_valid[1] = 1'b1;
    mem_rdata[1]      = 32'hDEAD_BEEF;
    @(negedge clock);
    check("ifu rd early", ifu_resp_valid[1], 0);
    drive_phase();
    mem_resp_valid[1] = 1'b0;
    @(negedge clock);
    check("ifu rd pulse", {ifu_resp_valid[1], ifu_resp_err[1], lsu_resp_valid[1]}, 3'b100);
    check("ifu rd data", ifu_rdata[1], 32'hDEAD_BEEF);
    drive_phase();
    @(negedge clock);
    check("ifu rd one-cycle", ifu_resp_valid[1], 0);
    check("ifu rd hold", ifu_rdata[1], 32'hDEAD_BEEF);

    // LSU byte store on dut1 with bus back-pressure and a slow ack (watchdog off).
    drive_phase();
    lsu_req_valid[1] = 1'b1;
    lsu_addr[1]      = 32'h0000_0100;
    lsu_wen[1]       = 1'b1;
    lsu_wdata[1]     = 32'h1234_5678;
    lsu_mask[1]      = 2'd0;
    mem_req_ready[1] = 1'b0;
    @(negedge clock);
    check("st ready", lsu_req_ready[1], 1);
    drive_phase();
    lsu_req_valid[1] = 1'b0;
    lsu_addr[1]      = 32'hFFFF_FFFF;
    lsu_wdata[1]     = 32'h0;
    lsu_mask[1]      = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("st held", {mem_req_valid[1], mem_wen[1], mem_mask[1], mem_addr[1]},
            {1'b1, 1'b1, 2'd0, 32'h0000_0100});
      check("st held wdata", mem_wdata[1], 32'h1234_5678);
      drive_phase();
    end
    mem_req_ready[1] = 1'b1;
    @(negedge clock);
    check("st handshake", mem_req_valid[1], 1);
    drive_phase();
    mem_req_ready[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("st waiting", {mem_req_valid[1], lsu_resp_valid[1], ifu_resp_valid[1]}, 0);
      drive_phase();
    end
    mem_resp_valid[1] = 1'b1;
    mem_rdata[1]      = 32'h0;
    @(negedge clock);
    drive_phase();
    mem_resp_valid[1] = 1'b0;
    @(negedge clock);
    check("st ack", {lsu_resp_valid[1], lsu_resp_err[1], ifu_resp_valid[1]}, 3'b100);

    // Watchdog on dut0: no response, error pulse 4 cycles after WAIT entry, late resp dropped.
    drive_phase();
    lsu_req_valid[0] = 1'b1;
    lsu_addr[0]      = 32'h0000_0200;
    lsu_wen[0]       = 1'b0;
    lsu_mask[0]      = 2'd2;
    mem_req_ready[0] = 1'b1;
    @(negedge clock);
    check("to ready", lsu_req_ready[0], 1);
    drive_phase();
    lsu_req_valid[0] = 1'b0;
    @(negedge clock);
    check("to issue", mem_req_valid[0], 1);
    drive_phase();
    mem_req_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("to no early pulse", {lsu_resp_valid[0], ifu_resp_valid[0]}, 0);
      drive_phase();
    end
    @(negedge clock);
    check("to pulse", {lsu_resp_valid[0], lsu_resp_err[0], ifu_resp_valid[0]}, 3'b110);
    check("to rdata", lsu_rdata[0], 0);
    drive_phase();
    @(negedge clock);
    check("to one-cycle", lsu_resp_valid[0], 0);
    drive_phase();
    mem_resp_valid[0] = 1'b1;
    mem_rdata[0]      = 32'h0000_0BAD;
    @(negedge clock);
    drive_phase();
    mem_resp_valid[0] = 1'b0;
    @(negedge clock);
    check("late resp dropped", {lsu_resp_valid[0], ifu_resp_valid[0]}, 0);
    check("late resp rdata", lsu_rdata[0], 0);

    // Reset during WAIT on dut0 (LSU owned, so last_grant=LSU before reset).
    drive_phase();
    lsu_req_valid[0] = 1'b1;
    lsu_addr[0]      = 32'h0000_0300;
    mem_req_ready[0] = 1'b1;
    @(negedge clock);
    drive_phase();
    lsu_req_valid[0] = 1'b0;
    @(negedge clock);
    check("rst txn issue", mem_req_valid[0], 1);
    drive_phase();
    reset = 1'b0;
    @(negedge clock);
    drive_phase();
    reset             = 1'b1;
    ifu_req_valid[0]  = 1'b1;
    ifu_addr[0]       = 32'h0000_0500;
    lsu_req_valid[0]  = 1'b1;
    lsu_addr[0]       = 32'h0000_0600;
    mem_resp_valid[0] = 1'b1;
    mem_rdata[0]      = 32'h5555_5555;
    @(negedge clock);
    check("rst abort", {mem_req_valid[0], lsu_resp_valid[0], ifu_resp_valid[0]}, 0);
    check("rst fields", {mem_addr[0], mem_wen[0], mem_mask[0]}, 0);
    check("rst tie grant", {ifu_req_ready[0], lsu_req_ready[0]}, 2'b01);
    drive_phase();
    ifu_req_valid[0]  = 1'b0;
    lsu_req_valid[0]  = 1'b0;
    mem_resp_valid[0] = 1'b0;
    @(negedge clock);
    check("rst new issue", {mem_req_valid[0], mem_addr[0]}, {1'b1, 32'h0000_0600});
    check("rst stale dropped", {lsu_resp_valid[0], ifu_resp_valid[0]}, 0);
    drive_phase();
    mem_resp_valid[0] = 1'b1;
    mem_rdata[0]      = 32'h0000_600D;
    @(negedge clock);
    drive_phase();
    mem_resp_valid[0] = 1'b0;
    @(negedge clock);
    check("rst new resp", {lsu_resp_valid[0], lsu_resp_err[0]}, 2'b10);
    check("rst new rdata", lsu_rdata[0], 32'h0000_600D);

    // Randomised stress on dut0 against a transaction-level model.
    do_reset();
    ifu_pend = 0; lsu_pend = 0; outstanding = 0; issue_pend = 0; exp_valid = 0;
    model_last = 0; accepted = 0; done = 0; cyc = 0;
    resp_cycle = -1; win_lo = 1; win_hi = 0; exp_cycle = -1;
    last_rd[0] = '0; last_rd[1] = '0;
    ifu_a = '0; lsu_a = '0; lsu_wd = '0; lsu_w = 0; lsu_m = '0;
    while ((accepted < NTxn || outstanding) && cyc < MaxCyc) begin
      drive_phase();
      cyc++;
      if (accepted < NTxn) begin
        if (!ifu_pend) begin
          if ($urandom_range(0, 1) == 0) begin
            ifu_pend = 1;
            ifu_a    = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) ifu_pend = 0;
        if (!lsu_pend) begin
          if ($urandom_range(0, 1) == 0) begin
            lsu_pend = 1;
            lsu_a    = $urandom;
            lsu_w    = $urandom_range(0, 1) == 1;
            lsu_wd   = $urandom;
            lsu_m    = 2'($urandom_range(0, 2));
          end
        end else if ($urandom_range(0, 15) == 0) lsu_pend = 0;
      end else begin
        ifu_pend = 0;
        lsu_pend = 0;
      end
      ifu_req_valid[0] = ifu_pend;
      ifu_addr[0]      = ifu_a;
      lsu_req_valid[0] = lsu_pend;
      lsu_addr[0]      = lsu_a;
      lsu_wen[0]       = lsu_w;
      lsu_wdata[0]     = lsu_wd;
      lsu_mask[0]      = lsu_m;
      mem_req_ready[0] = ($urandom_range(0, 2) != 0);
      if (cyc == resp_cycle) begin
        mem_resp_valid[0] = 1'b1;
        mem_rdata[0]      = resp_data;
      end else if ((cyc < win_lo || cyc > win_hi) && $urandom_range(0, 7) == 0) begin
        mem_resp_valid[0] = 1'b1;
        mem_rdata[0]      = $urandom;
      end else begin
        mem_resp_valid[0] = 1'b0;
        mem_rdata[0]      = $urandom;
      end
      @(negedge clock);

      if (exp_valid && cyc == exp_cycle) begin
        check("stress resp owner", {ifu_resp_valid[0], lsu_resp_valid[0]},
              (exp_owner == 1) ? 2'b01 : 2'b10);
        check("stress resp err", (exp_owner == 1) ? lsu_resp_err[0] : ifu_resp_err[0],
              exp_err);
        check("stress resp rdata", (exp_owner == 1) ? lsu_rdata[0] : ifu_rdata[0], exp_data);
        check("stress other rdata", (exp_owner == 1) ? ifu_rdata[0] : lsu_rdata[0],
              last_rd[1 - exp_owner]);
        last_rd[exp_owner] = exp_data;
        exp_valid   = 0;
        outstanding = 0;
        done++;
      end else begin
        check("stress spurious resp", {ifu_resp_valid[0], lsu_resp_valid[0]}, 2'b00);
      end

      check("stress mem_req_valid", mem_req_valid[0], issue_pend);
      if (issue_pend && mem_req_valid[0]) begin
        check("stress mem fields", {mem_addr[0], mem_wen[0], mem_mask[0]},
              {cur_addr, cur_w, cur_m});
        check("stress mem wdata", mem_wdata[0], cur_wd);
        if (mem_req_ready[0]) begin
          issue_pend = 0;
          dly        = $urandom_range(0, 4);
          resp_data  = $urandom;
          resp_cycle = cyc + 1 + dly;
          win_lo     = cyc + 1;
          win_hi     = cyc + 1 + ((dly < 4) ? dly : 3);
          exp_valid  = 1;
          exp_owner  = cur_owner;
          exp_err    = (dly == 4);
          exp_data   = (dly == 4) ? 32'h0 : resp_data;
          exp_cycle  = (dly < 4) ? cyc + 2 + dly : cyc + 5;
        end
      end

      ei = 0;
      el = 0;
      if (!outstanding) begin
        if (ifu_pend && lsu_pend) begin
          el = (model_last == 0);
          ei = !el;
        end else begin
          ei = ifu_pend;
          el = lsu_pend;
        end
      end
      check("stress grant", {ifu_req_ready[0], lsu_req_ready[0]}, {ei, el});
      if (ei || el) begin
        outstanding = 1;
        issue_pend  = 1;
        cur_owner   = el ? 1 : 0;
        model_last  = cur_owner;
        cur_addr    = el ? lsu_a : ifu_a;
        cur_w       = el ? lsu_w : 1'b0;
        cur_wd      = el ? lsu_wd : 32'h0;
        cur_m       = el ? lsu_m : 2'd2;
        if (el) lsu_pend = 0;
        else ifu_pend = 0;
        accepted++;
      end
    end
    check("stress responses", done, NTxn);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
